// File: rtl/mastermind_fsm.sv
// Game sequencing FSM for the Mastermind datapath: code entry, guess entry,
// per-peg compare sweep, win/lose decision and synchronous restart.
//
// state      | meaning
// -----------+----------------------------------------------------------
// CODE       | load_code high, waiting for a press on code slot slot_idx
// CODE_WAIT  | code slot pressed, waiting for button release
// GUESS      | load_guess high, waiting for a press on guess slot slot_idx
// GUESS_WAIT | guess slot pressed, waiting for button release
// CMP        | compare strobe sweeping pegs 0..PEGS-1
// RESULT     | result_valid pulse, exact_match sampled, attempt counted
// END        | win/lose held, waiting for a press
// END_WAIT   | waiting for release before starting a new game
module mastermind_fsm #(
    parameter int PEGS      = 4,
    parameter int MAX_TRIES = 8,
    localparam int IDX_W    = ($clog2(PEGS) < 1) ? 1 : $clog2(PEGS),
    localparam int TRY_W    = ($clog2(MAX_TRIES + 1) < 1) ? 1 : $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             restart,
    input  logic             exact_match,
    output logic             load_code,
    output logic             load_guess,
    output logic [IDX_W-1:0] slot_idx,
    output logic             compare,
    output logic [IDX_W-1:0] compare_i,
    output logic             result_valid,
    output logic [TRY_W-1:0] attempt,
    output logic             win,
    output logic             lose
);

    localparam logic [2:0] S_CODE       = 3'd0;
    localparam logic [2:0] S_CODE_WAIT  = 3'd1;
    localparam logic [2:0] S_GUESS      = 3'd2;
    localparam logic [2:0] S_GUESS_WAIT = 3'd3;
    localparam logic [2:0] S_CMP        = 3'd4;
    localparam logic [2:0] S_RESULT     = 3'd5;
    localparam logic [2:0] S_END        = 3'd6;
    localparam logic [2:0] S_END_WAIT   = 3'd7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PEGS - 1);
    localparam logic [TRY_W-1:0] MAX_T    = TRY_W'(MAX_TRIES);

    logic [2:0]       state;
    logic [IDX_W-1:0] slot_q;
    logic [IDX_W-1:0] cmp_q;
    logic [TRY_W-1:0] attempt_q;
    logic             win_q;
    logic             lose_q;
    logic [TRY_W-1:0] attempt_inc;

    // Saturating increment so attempt can never exceed MAX_TRIES
    always_comb begin
        attempt_inc = attempt_q;
        if (attempt_q != MAX_T) begin
            attempt_inc = attempt_q + TRY_W'(1);
        end
    end

    // State and counter update; restart overrides every state action
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_CODE;
            slot_q    <= '0;
            cmp_q     <= '0;
            attempt_q <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else if (restart) begin
            state     <= S_CODE;
            slot_q    <= '0;
            cmp_q     <= '0;
            attempt_q <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            case (state)
                S_CODE: begin
                    if (load) state <= S_CODE_WAIT;
                end
                S_CODE_WAIT: begin
                    if (!load) begin
                        if (slot_q == LAST_IDX) begin
                            slot_q <= '0;
                            state  <= S_GUESS;
                        end else begin
                            slot_q <= slot_q + IDX_W'(1);
                            state  <= S_CODE;
                        end
                    end
                end
                S_GUESS: begin
                    if (load) state <= S_GUESS_WAIT;
                end
                S_GUESS_WAIT: begin
                    if (!load) begin
                        if (slot_q == LAST_IDX) begin
                            slot_q <= '0;
                            cmp_q  <= '0;
                            state  <= S_CMP;
                        end else begin
                            slot_q <= slot_q + IDX_W'(1);
                            state  <= S_GUESS;
                        end
                    end
                end
                S_CMP: begin
                    if (cmp_q == LAST_IDX) begin
                        cmp_q <= '0;
                        state <= S_RESULT;
                    end else begin
                        cmp_q <= cmp_q + IDX_W'(1);
                    end
                end
                S_RESULT: begin
                    attempt_q <= attempt_inc;
                    if (exact_match) begin
                        win_q <= 1'b1;
                        state <= S_END;
                    end else if (attempt_inc == MAX_T) begin
                        lose_q <= 1'b1;
                        state  <= S_END;
                    end else begin
                        state <= S_GUESS;
                    end
                end
                S_END: begin
                    if (load) state <= S_END_WAIT;
                end
                S_END_WAIT: begin
                    if (!load) begin
                        state     <= S_CODE;
                        slot_q    <= '0;
                        attempt_q <= '0;
                        win_q     <= 1'b0;
                        lose_q    <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_CODE;
                    slot_q    <= '0;
                    cmp_q     <= '0;
                    attempt_q <= '0;
                    win_q     <= 1'b0;
                    lose_q    <= 1'b0;
                end
            endcase
        end
    end

    // Moore outputs decoded from state and counters
    assign load_code    = (state == S_CODE);
    assign load_guess   = (state == S_GUESS);
    assign slot_idx     = slot_q;
    assign compare      = (state == S_CMP);
    assign compare_i    = (state == S_CMP) ? cmp_q : '0;
    assign result_valid = (state == S_RESULT);
    assign attempt      = attempt_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_mastermind_fsm.sv
// Directed bench for mastermind_fsm with PEGS=4, MAX_TRIES=3.
module tb_mastermind_fsm;

    localparam int PEGS      = 4;
    localparam int MAX_TRIES = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       load;
    logic       restart;
    logic       exact_match;
    logic       load_code;
    logic       load_guess;
    logic [1:0] slot_idx;
    logic       compare;
    logic [1:0] compare_i;
    logic       result_valid;
    logic [1:0] attempt;
    logic       win;
    logic       lose;

    int vecs = 0;
    int errs = 0;

    mastermind_fsm #(.PEGS(PEGS), .MAX_TRIES(MAX_TRIES)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load         (load),
        .restart      (restart),
        .exact_match  (exact_match),
        .load_code    (load_code),
        .load_guess   (load_guess),
        .slot_idx     (slot_idx),
        .compare      (compare),
        .compare_i    (compare_i),
        .result_valid (result_valid),
        .attempt      (attempt),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One press/release pair; the button is held for 'hold' wait cycles
    task automatic enter_slot(input int hold);
        load = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("wait_no_load_code", load_code, 0);
            chk("wait_no_load_guess", load_guess, 0);
        end
        load = 1'b0;
        tick();
    endtask

    task automatic enter_code(input int hold);
        for (int s = 0; s < PEGS; s++) begin
            chk("code_load_code", load_code, 1);
            chk("code_slot_idx", slot_idx, s);
            enter_slot(hold);
        end
    endtask

    task automatic enter_guess();
        for (int s = 0; s < PEGS; s++) begin
            chk("guess_load_guess", load_guess, 1);
            chk("guess_slot_idx", slot_idx, s);
            enter_slot(1);
        end
    endtask

    // Ends positioned in the RESULT cycle
    task automatic sweep();
        for (int i = 0; i < PEGS; i++) begin
            chk("cmp_compare", compare, 1);
            chk("cmp_compare_i", compare_i, i);
            chk("cmp_no_result", result_valid, 0);
            tick();
        end
        chk("result_valid", result_valid, 1);
        chk("result_no_compare", compare, 0);
    endtask

    initial begin
        resetn      = 1'b0;
        load        = 1'b0;
        restart     = 1'b0;
        exact_match = 1'b0;
        #3;
        chk("rst_load_code", load_code, 1);
        chk("rst_load_guess", load_guess, 0);
        chk("rst_compare", compare, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_attempt", attempt, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_slot_idx", slot_idx, 0);
        #9 resetn = 1'b1;
        tick();

        // Code entry with long holds, then first guess slot
        enter_code(5);
        chk("after_code_load_guess", load_guess, 1);
        chk("after_code_load_code", load_code, 0);
        chk("after_code_slot", slot_idx, 0);

        // Win on first guess; exact_match high throughout, only RESULT uses it
        exact_match = 1'b1;
        enter_guess();
        chk("cmp_win_not_early", win, 0);
        sweep();
        chk("result_attempt_old", attempt, 0);
        tick();
        exact_match = 1'b0;
        chk("win_set", win, 1);
        chk("win_attempt", attempt, 1);
        chk("win_no_lose", lose, 0);
        chk("win_rv_pulse", result_valid, 0);
        repeat (3) tick();
        chk("win_held", win, 1);
        load = 1'b1;
        tick();
        chk("win_held_wait", win, 1);
        load = 1'b0;
        tick();
        chk("newgame_win", win, 0);
        chk("newgame_attempt", attempt, 0);
        chk("newgame_load_code", load_code, 1);
        chk("newgame_slot", slot_idx, 0);

        // Loss after MAX_TRIES wrong guesses
        enter_code(1);
        for (int g = 1; g <= MAX_TRIES; g++) begin
            enter_guess();
            sweep();
            tick();
            if (g < MAX_TRIES) begin
                chk("loss_attempt", attempt, g);
                chk("loss_back_guess", load_guess, 1);
                chk("loss_slot", slot_idx, 0);
                chk("loss_no_lose", lose, 0);
            end else begin
                chk("lose_set", lose, 1);
                chk("lose_attempt", attempt, MAX_TRIES);
                chk("lose_no_win", win, 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lose_no_load_guess", load_guess, 0);
            chk("lose_held", lose, 1);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_end_code", load_code, 1);
        chk("restart_end_lose", lose, 0);
        chk("restart_end_attempt", attempt, 0);

        // Restart in RESULT beats exact_match
        enter_code(1);
        enter_guess();
        exact_match = 1'b1;
        sweep();
        restart = 1'b1;
        tick();
        restart     = 1'b0;
        exact_match = 1'b0;
        chk("rprio_load_code", load_code, 1);
        chk("rprio_win", win, 0);
        chk("rprio_attempt", attempt, 0);
        chk("rprio_rv", result_valid, 0);
        tick();
        chk("rprio_still_code", load_code, 1);
        chk("rprio_still_nowin", win, 0);

        // Restart in GUESS_WAIT with button held
        enter_code(1);
        chk("rwait_guess0", load_guess, 1);
        enter_slot(1);
        chk("rwait_slot1", slot_idx, 1);
        load = 1'b1;
        tick();
        chk("rwait_in_wait", load_guess, 0);
        chk("rwait_slot_wait", slot_idx, 1);
        restart = 1'b1;
        tick();
        chk("rwait_code", load_code, 1);
        chk("rwait_slot0", slot_idx, 0);
        restart = 1'b0;
        load    = 1'b0;
        tick();
        chk("rwait_release_code", load_code, 1);
        chk("rwait_release_slot", slot_idx, 0);

        // Asynchronous reset in the middle of a compare sweep
        enter_code(1);
        enter_guess();
        sweep();
        tick();
        chk("mid_attempt1", attempt, 1);
        enter_guess();
        chk("mid_compare", compare, 1);
        tick();
        chk("mid_compare_i", compare_i, 1);
        resetn = 1'b0;
        #2;
        chk("mid_rst_load_code", load_code, 1);
        chk("mid_rst_compare", compare, 0);
        chk("mid_rst_compare_i", compare_i, 0);
        chk("mid_rst_attempt", attempt, 0);
        chk("mid_rst_slot", slot_idx, 0);
        #2 resetn = 1'b1;
        tick();
        chk("post_rst_code", load_code, 1);
        chk("post_rst_slot", slot_idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mastermind_fsm.md
# mastermind_fsm

Parametrised game-sequencing FSM for the Mastermind datapath. It walks the player through entering a secret code of `PEGS` slots and up to `MAX_TRIES` guesses, then sweeps a per-peg compare strobe. It decides win/lose from the datapath's exact-match flag and supports a synchronous restart. It drives the code/guess registers and compare unit.

## Interface
- `PEGS`, 4: pegs per code/guess, ≥2.
- `MAX_TRIES`, 8: guesses allowed before loss, ≥1.
- `IDX_W`, derived: `max(1, clog2(PEGS))`, slot/compare index width.
- `TRY_W`, derived: `clog2(MAX_TRIES+1)`, attempt counter width.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `load`  in  1  player button level, already synchronised; a press is high then low.
- `restart`  in  1  synchronous abort to code entry, highest priority after reset.
- `exact_match`  in  1  datapath flag: all pegs correct; must be valid in the `result_valid` cycle.
- `load_code`  out  1  write enable for code slot `slot_idx`.
- `load_guess`  out  1  write enable for guess slot `slot_idx`.
- `slot_idx`  out  IDX_W  slot currently being entered.
- `compare`  out  1  compare strobe.
- `compare_i`  out  IDX_W  peg index being compared.
- `result_valid`  out  1  one-cycle pulse; the datapath presents `exact_match`.
- `attempt`  out  TRY_W  completed guesses this game.
- `win`  out  1  game won; held.
- `lose`  out  1  game lost; held.

## Operation
- All outputs are Moore, decoded from state and counters only.
- **States:** CODE, CODE_WAIT, GUESS, GUESS_WAIT, CMP, RESULT, END, END_WAIT.
- **CODE:** `load_code`=1.
  - `load`=1 → CODE_WAIT.
- **CODE_WAIT:**
  - Holds while `load`=1.
  - On `load`=0: if `slot_idx`==PEGS-1, `slot_idx`←0 → GUESS; else `slot_idx`++ → CODE.
- **GUESS / GUESS_WAIT:** identical to the CODE pair, with `load_guess`=1 in GUESS. After the last slot: `slot_idx`←0, compare counter←0 → CMP.
- **CMP:**
  - `compare`=1 and `compare_i`=counter.
  - The counter steps 0..PEGS-1, one per cycle.
  - After PEGS-1 → RESULT.
  - `load` is ignored.
- **RESULT:**
  - `result_valid`=1 and `attempt`++ (saturating at MAX_TRIES).
  - If `exact_match`: set `win` → END.
  - Else if the incremented attempt==MAX_TRIES: set `lose` → END.
  - Else → GUESS.
- **END:**
  - `win`/`lose` are held.
  - `load`=1 → END_WAIT; on release → CODE, with `win`, `lose`, `attempt` and `slot_idx` cleared.
- **`restart`=1 in any state:** next state CODE, and `slot_idx`, compare counter, `attempt`, `win` and `lose` are all cleared.
- **Unreachable state encodings** → CODE, with counters cleared.
- **Counters never wrap.** `slot_idx` and `compare_i` are bounded by PEGS-1; `attempt` never exceeds MAX_TRIES.

## Timing
- **Reset (asynchronous, `resetn`=0):**
  - State is CODE and all counters are 0.
  - `load_code`=1; every other output is 0.
  - Outputs take these values immediately, without a clock edge.
- **Reset release:** first transition on the first rising edge with `resetn`=1.
- **Slot entry latency:** one slot costs ≥2 cycles: press edge → WAIT, release edge → next slot. `load_code`/`load_guess` are high only in the CODE/GUESS state, never in WAIT.
- **`load` held across the last slot:** no advance until release. A button held through many cycles enters exactly one slot.
- **Compare sweep:** exactly PEGS cycles of `compare`, then one RESULT cycle. The last guess release to `result_valid` is PEGS+1 cycles.
- **`restart` coincident with `load` or `exact_match`:** `restart` wins and no counter increments.
- **`exact_match` outside RESULT:** ignored.

## Test plan
(All scenarios use PEGS=4, MAX_TRIES=3.)
- **Reset mid-game:** drive `resetn` low during CMP → outputs immediately `load_code`=1, `compare`=0, `attempt`=0, `slot_idx`=0 (no clock edge).
- **Code entry:**
  - Stimulus: 4 press/release pairs, holding each press 5 cycles.
  - Required: `load_code` high with `slot_idx`=0,1,2,3 in turn.
  - Required: never high during the hold cycles.
  - Required: then `load_guess`=1 with `slot_idx`=0.
- **Win on first guess:** enter 4 guess slots with `exact_match`=1 → `compare_i` sequence 0,1,2,3, then `result_valid` one cycle, then `win`=1, `attempt`=1, held until a press/release, then back to CODE with `win`=0.
- **Loss:**
  - Stimulus: three guesses with `exact_match`=0.
  - Required: after guesses 1 and 2, `attempt`=1 and 2 and the FSM returns to GUESS.
  - Required: after guess 3, `lose`=1 and `attempt`=3.
  - Required: no further `load_guess`.
- **Restart priority:** assert `restart` in the RESULT cycle with `exact_match`=1 → next cycle CODE, `win`=0, `attempt`=0.
- **Restart in the wait state:** assert `restart` in GUESS_WAIT with `load`=1 held → CODE, `slot_idx`=0, and no slot increment on the subsequent release.
